// File: rtl/vga_timing_if.sv
// vga_timing_if: raster/pixel bundle between the timing generator and the
// TMDS encoder side.
//   pix_red/green/blue : external pixel colour into the generator
//   x, y               : live horizontal/vertical counters
//   hsync, vsync, blank, red, green, blue, frame_start : registered outputs
// master = timing generator, slave = consumer/pixel source.
interface vga_timing_if #(
  parameter int unsigned CNT_W = 10
) ();
  logic [2:0]       pix_red;
  logic [2:0]       pix_green;
  logic [2:0]       pix_blue;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             hsync;
  logic             vsync;
  logic             blank;
  logic [2:0]       red;
  logic [2:0]       green;
  logic [2:0]       blue;
  logic             frame_start;

  modport master (
    input  pix_red, pix_green, pix_blue,
    output x, y, hsync, vsync, blank, red, green, blue, frame_start
  );

  modport slave (
    output pix_red, pix_green, pix_blue,
    input  x, y, hsync, vsync, blank, red, green, blue, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster timing generator (sizes parameterised).
// Ports:
//   clk   - pixel clock, all state on rising edge
//   reset - asynchronous, active-high
//   vga   - vga_timing_if.master: pix_* in; x/y (combinational from the
//           counters); hsync, vsync, blank, red, green, blue, frame_start
//           (registered, one cycle behind x/y)
// Build option: define TEST_PATTERN_EN to replace pix_* with 8 vertical colour
// bars (red = bar, green = ~bar, blue = vcount[7:5]).
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All decode constants are held at counter width.
  localparam logic [CNT_W-1:0] HLast      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HActive    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncStart = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncStart = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             h_last, v_last, active;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             blank_q, blank_d, frame_start_q, frame_start_d;
  logic [2:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [2:0]       red_c, green_c, blue_c;

  // Raster counters and per-pixel decode.
  always_comb begin
    h_last = (hcnt_q == HLast);
    v_last = (vcnt_q == VLast);
    hcnt_d = h_last ? '0 : hcnt_q + CNT_W'(1);
    vcnt_d = vcnt_q;
    if (h_last) begin
      vcnt_d = v_last ? '0 : vcnt_q + CNT_W'(1);
    end

    active        = (hcnt_q < HActive) && (vcnt_q < VActive);
    blank_d       = ~active;
    hsync_d       = ((hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    red_d         = active ? red_c   : 3'd0;
    green_d       = active ? green_c : 3'd0;
    blue_d        = active ? blue_c  : 3'd0;
  end

`ifdef TEST_PATTERN_EN
  // Bar width is an elaboration-time constant; the bar index advances by
  // counting pixels within a bar rather than dividing hcount.
  localparam logic [CNT_W-1:0] BarLast = CNT_W'(H_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] bar_px_q, bar_px_d;
  logic [2:0]       bar_q, bar_d;

  always_comb begin
    bar_px_d = bar_px_q;
    bar_d    = bar_q;
    if (h_last) begin
      // Clear on the last pixel so both read zero while hcount == 0.
      bar_px_d = '0;
      bar_d    = 3'd0;
    end else if (hcnt_q < HActive) begin
      if (bar_px_q == BarLast) begin
        bar_px_d = '0;
        bar_d    = bar_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + CNT_W'(1);
      end
    end
    red_c   = bar_q;
    green_c = ~bar_q;
    blue_c  = vcnt_q[7:5];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_px_q <= '0;
      bar_q    <= 3'd0;
    end else begin
      bar_px_q <= bar_px_d;
      bar_q    <= bar_d;
    end
  end
`else
  always_comb begin
    red_c   = vga.pix_red;
    green_c = vga.pix_green;
    blue_c  = vga.pix_blue;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      red_q         <= 3'd0;
      green_q       <= 3'd0;
      blue_q        <= 3'd0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign vga.x           = hcnt_q;
  assign vga.y           = vcnt_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank       = blank_q;
  assign vga.frame_start = frame_start_q;
  assign vga.red         = red_q;
  assign vga.green       = green_q;
  assign vga.blue        = blue_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing with a scaled-down raster (80 x 81) so several frames fit
// in a short run. Expected outputs come from a bench-side raster model and are
// queued per pixel, then compared once the DUT registers that pixel.
module tb_vga_timing;
  localparam int unsigned HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int unsigned VA = 72, VF = 3, VS = 2, VB = 4;
  localparam int unsigned CW = 10;
  localparam bit          POL = 1'b0;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam logic [12:0] RstVec = {1'b0, 1'b1, ~POL, ~POL, 9'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_timing_if #(.CNT_W(CW)) vif ();

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vga  (vif)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [12:0] sb[$];
  int unsigned mh, mv;
  int unsigned hs_cnt, hs_first, bl_cnt, vs_line, vs_frame, fs_gap, fs_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, got, exp, mh, mv,
               $time);
    end
  endtask

  function automatic logic [12:0] model_out(input int unsigned h, input int unsigned v);
    logic       act, hs, vs, fs;
    logic [2:0] r, g, b;
    logic [9:0] vv;
    act = (h < HA) && (v < VA);
    hs  = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
    vs  = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
    fs  = (h == 0) && (v == 0);
    vv  = 10'(v);
`ifdef TEST_PATTERN_EN
    r = 3'(h / (HA / 8));
    g = ~r;
    b = vv[7:5];
`else
    r = 3'(h);
    g = 3'(h >> 3);
    b = vv[2:0];
`endif
    if (!act) begin
      r = 3'd0;
      g = 3'd0;
      b = 3'd0;
    end
    return {fs, ~act, hs, vs, r, g, b};
  endfunction

  function automatic logic [12:0] obs();
    return {vif.frame_start, vif.blank, vif.hsync, vif.vsync, vif.red, vif.green, vif.blue};
  endfunction

  task automatic restart_model();
    mh = 0; mv = 0;
    hs_cnt = 0; hs_first = '1; bl_cnt = 0; vs_line = 0; vs_frame = 0;
    fs_gap = 0; fs_count = 0;
    sb.delete();
  endtask

  // Entered just after a falling edge; each pass covers one pixel.
  task automatic run_cycles(input int unsigned n);
    logic [12:0] got, exp;
    for (int unsigned i = 0; i < n; i++) begin
      vif.pix_red   = 3'(mh);
      vif.pix_green = 3'(mh >> 3);
      vif.pix_blue  = 3'(mv);
      check_eq("x", 32'(vif.x), mh);
      check_eq("y", 32'(vif.y), mv);
      sb.push_back(model_out(mh, mv));
      @(negedge clk);
      got = obs();
      exp = sb.pop_front();
      check_eq("out", 32'(got), 32'(exp));
      if (got[10] == POL) begin
        if (hs_cnt == 0) hs_first = mh;
        hs_cnt++;
      end
      if (got[11]) bl_cnt++;
      if (got[9] == POL) begin
        vs_line++;
        vs_frame++;
      end
      fs_gap++;
      if (got[12]) begin
        if (fs_count > 0) check_eq("fs_period", fs_gap, FRAME);
        fs_gap = 0;
        fs_count++;
      end
      if (mh == HT - 1) begin
        check_eq("hs_low_len", hs_cnt, HS);
        check_eq("hs_first", hs_first, HA + HF);
        check_eq("blank_len", bl_cnt, (mv < VA) ? HT - HA : HT);
        check_eq("vs_line", vs_line, (mv >= VA + VF && mv < VA + VF + VS) ? HT : 0);
        if (mv == VT - 1) begin
          check_eq("vs_frame", vs_frame, VS * HT);
          vs_frame = 0;
        end
        hs_cnt = 0; hs_first = '1; bl_cnt = 0; vs_line = 0;
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  endtask

  initial begin
    vif.pix_red = 3'd0; vif.pix_green = 3'd0; vif.pix_blue = 3'd0;
    restart_model();
    repeat (3) @(negedge clk);
    check_eq("rst_out", 32'(obs()), 32'(RstVec));
    check_eq("rst_x", 32'(vif.x), 0);
    check_eq("rst_y", 32'(vif.y), 0);
    reset = 1'b0;

    // Frame 0 fully, then into frame 1 up to line 20, pixel 30.
    run_cycles(FRAME + 20 * HT + 30);
    check_eq("fs_count_a", fs_count, 2);

    // Mid-frame asynchronous reset, checked before the next rising edge.
    #1 reset = 1'b1;
    #1;
    check_eq("async_rst_out", 32'(obs()), 32'(RstVec));
    check_eq("async_rst_x", 32'(vif.x), 0);
    check_eq("async_rst_y", 32'(vif.y), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("held_rst_out", 32'(obs()), 32'(RstVec));
    reset = 1'b0;
    restart_model();

    run_cycles(FRAME + 5);
    check_eq("fs_count_b", fs_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
